// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM output peripheral.
// The pin mux helper is shared by the RTL and anyone needing the same pin rule.
package pwm_pkg;

    localparam int                    PWM_CNT_W       = 8;
    localparam logic [PWM_CNT_W-1:0]  DUTY_FULL       = 8'hFF;
    localparam int                    DEFAULT_CLK_DIV = 13;

    typedef logic [15:0] pin_vec_t;

    // A pin is high when enabled and either static or following the PWM level.
    function automatic pin_vec_t pinDrive(input pin_vec_t enOut,
                                          input pin_vec_t enPwm,
                                          input logic     level);
        return enOut & (~enPwm | {16{level}});
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, 8-bit period counter, duty shadow register.
// Produces the combinational PWM level and a registered period-start pulse.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PWM_CNT_W-1:0] duty_i,
    output logic                 pwm_level_o,
    output logic                 period_start_o
);

    localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

    logic [15:0]          prescaler_q, prescaler_d;
    logic [PWM_CNT_W-1:0] pwmCnt_q, pwmCnt_d;
    logic [PWM_CNT_W-1:0] dutyShadow_q, dutyShadow_d;
    logic                 periodStart_q, periodStart_d;
    logic                 freshReset_q;
    logic                 tick;
    logic                 wrapTick;

    // Duty only moves into the shadow on the last tick of a period, so a
    // period never sees a partially applied duty value.
    always_comb begin
        tick          = (prescaler_q == PRESC_MAX);
        wrapTick      = tick && (pwmCnt_q == '1);
        prescaler_d   = tick ? 16'd0 : prescaler_q + 16'd1;
        pwmCnt_d      = tick ? pwmCnt_q + 8'd1 : pwmCnt_q;
        dutyShadow_d  = wrapTick ? duty_i : dutyShadow_q;
        periodStart_d = wrapTick | freshReset_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q   <= '0;
            pwmCnt_q      <= '0;
            dutyShadow_q  <= '0;
            periodStart_q <= 1'b0;
            freshReset_q  <= 1'b1;
        end else begin
            prescaler_q   <= prescaler_d;
            pwmCnt_q      <= pwmCnt_d;
            dutyShadow_q  <= dutyShadow_d;
            periodStart_q <= periodStart_d;
            freshReset_q  <= 1'b0;
        end
    end

    // Full-scale duty is special-cased so 0xFF gives a solid high period.
    assign pwm_level_o    = (dutyShadow_q == DUTY_FULL) || (pwmCnt_q < dutyShadow_q);
    assign period_start_o = periodStart_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin is low, static high, or the shared PWM level,
// selected by the SPI-written enable registers and registered once.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int CNT_W   = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       en_reg_out_7_0,
    input  logic [7:0]       en_reg_out_15_8,
    input  logic [7:0]       en_reg_pwm_7_0,
    input  logic [7:0]       en_reg_pwm_15_8,
    input  logic [CNT_W-1:0] pwm_duty_cycle,
    output logic [15:0]      out,
    output logic             period_start
);

    pin_vec_t enOut;
    pin_vec_t enPwm;
    pin_vec_t out_q, out_d;
    logic     pwmLevel;

    assign enOut = {en_reg_out_15_8, en_reg_out_7_0};
    assign enPwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk            (clk),
        .rst            (rst),
        .duty_i         (pwm_duty_cycle),
        .pwm_level_o    (pwmLevel),
        .period_start_o (period_start)
    );

    // Enables are not period-aligned; they take effect on the next clock.
    always_comb begin
        out_d = pinDrive(enOut, enPwm, pwmLevel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives 16 output pins.
- Each pin is one of: forced low, static high, or a shared 8-bit PWM waveform.
- Runs in the system clock domain, directly downstream of the SPI register block.
- Register inputs are already synchronous to clk and stable between writes.

Parameters:
CLK_DIV, 13, system clocks per PWM tick (10 MHz / 13 / 256 ≈ 3.0 kHz PWM); legal range 1..65535
CNT_W, 8, PWM counter / duty width; fixed at 8 for this revision

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en_reg_out_7_0  input  8  output enable, pins 7..0
en_reg_out_15_8  input  8  output enable, pins 15..8
en_reg_pwm_7_0  input  8  PWM select, pins 7..0
en_reg_pwm_15_8  input  8  PWM select, pins 15..8
pwm_duty_cycle  input  8  requested duty, 0x00 = 0 %, 0xFF = 100 %
out  output  16  pin drive, registered
period_start  output  1  one-cycle pulse at the first clk of each PWM period

Behaviour:
- Reset (rst high at a clk edge): prescaler=0, pwm_cnt=0, duty_shadow=0, out=16'h0000, period_start=0. Reset mid-period discards the period; the first period after reset begins with pwm_cnt=0.
- Prescaler: counts 0..CLK_DIV-1 and wraps to 0. tick=1 in the cycle where prescaler==CLK_DIV-1. With CLK_DIV=1, tick=1 every cycle.
- pwm_cnt (8 bit): increments on tick; wraps 255→0. Period = 256*CLK_DIV clocks.
- Duty shadow: on tick with pwm_cnt==255, duty_shadow <= pwm_duty_cycle. A duty write lands only at a period boundary, so there are no glitch or runt pulses mid-period. A write in the same cycle as the wrap tick is captured.
- pwm_level is combinational:
  - duty_shadow==0xFF → 1 for the whole period.
  - otherwise → (pwm_cnt < duty_shadow).
  - Result: high time = duty_shadow ticks per period (0..254); 0xFF = 256; 255/256 is unreachable by design.
- Per pin i, registered: out[i] <= en_out[i] ? (en_pwm[i] ? pwm_level : 1) : 0, where en_out={en_reg_out_15_8,en_reg_out_7_0} and en_pwm likewise.
- Latency: enable changes reach out one clk after they appear on the inputs; no period alignment for enables.
- en_pwm[i]=1 with en_out[i]=0 → pin low; the output enable has priority.
- period_start: registered; asserted for exactly one clk in the cycle after the wrap tick, aligned with the first out update of the new period. It also fires for the first period after reset, 1 clk after reset deasserts.
- All PWM pins share one counter and switch on the same clk edge.
- No state machine beyond the counters; there are no illegal states.

Decomposition:
- Shared package pwm_pkg:
  - PWM_CNT_W = 8
  - DUTY_FULL = 8'hFF
  - DEFAULT_CLK_DIV = 13
  - typedef pin_vec_t as logic [15:0]
- Sub-module pwm_timebase: contains prescaler, pwm_cnt, duty_shadow and period_start; exports pwm_level and period_start.
- pwm_peripheral: instantiates pwm_timebase and adds the 16-pin enable/select mux and the out register.

Test Plan:
- Reset, then en_out=16'hFFFF, en_pwm=0 → out=16'hFFFF one clk after the inputs change; set en_out=0 → out=0 one clk later.
- CLK_DIV=1, duty=0x80, en_out=en_pwm=16'h0001 → out[0] high exactly 128 of each 256 clks; rising edge 1 clk after period_start; other pins stay 0.
- duty=0x00 → out[0] constantly 0; duty=0xFF → constantly 1 across ≥3 periods, with period_start still pulsing every 256*CLK_DIV clks.
- Mid-period duty change 0x40→0xC0 at pwm_cnt=100 → current period finishes with 64 high ticks; next period has 192.
- Priority: en_out=16'h00FF, en_pwm=16'hFF00, duty=0x80 → pins 7..0 static high, pins 15..8 low.
- Assert rst for 1 clk at pwm_cnt≈200 → out=0 and period_start=0 the next clk; first period after release starts at pwm_cnt=0 with duty_shadow=0 (all PWM pins low) until the next boundary loads the new duty.
